td4_run_ctrl: RTL
=================

Name: td4_run_ctrl

Overview:
Run controller that sequences the TD4 core. It loads a 16-byte program into program memory over a valid/ready byte stream and holds the core in reset for a fixed number of cycles. It then runs the core free-running or single-stepped through a clock enable, and stops after a programmable cycle budget. It sits between the board/POR logic and TD4core and replaces ad-hoc bench cycle counting.

Parameters:
RST_CYCLES, 4, cycles core_rst_n is held low after load or restart (1..15)
MAX_CYCLES, 250, core_ce cycles before DONE; 0 = unlimited
CNT_W, 8, width of cycle_cnt; MAX_CYCLES must fit

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
ld_valid  in  1  program byte valid
ld_data  in  8  program byte (ROM word)
ld_ready  out  1  controller accepts byte
run_req  in  1  pulse: start/resume free run
step_req  in  1  pulse: execute one instruction
halt_req  in  1  pulse: pause
restart_req  in  1  pulse: re-reset core, keep program
prog_we  out  1  program memory write strobe
prog_addr  out  4  program memory address
prog_wdata  out  8  program memory write data
core_rst_n  out  1  active-low reset to TD4core
core_ce  out  1  core clock enable, one instruction per high cycle
state  out  3  current FSM state encoding
cycle_cnt  out  CNT_W  core_ce cycles since last release
done  out  1  cycle budget exhausted

Behaviour:
- Reset values: state=LOAD, ld_ready=1, prog_we=0, prog_addr=0, prog_wdata=0, core_rst_n=0, core_ce=0, cycle_cnt=0, done=0.
- States: LOAD=0, HOLD=1, PAUSE=2, RUN=3, STEP=4, DONE=5.
- LOAD: ld_ready=1. A handshake (ld_valid & ld_ready) registers prog_we=1, prog_wdata=ld_data, prog_addr=load pointer, visible the next cycle. The pointer increments and wraps 15->0. The 16th accepted byte moves the FSM to HOLD and drops ld_ready the same edge. core_rst_n stays 0 throughout LOAD.
- HOLD: core_rst_n=0 for exactly RST_CYCLES cycles, counted by the hold counter. At expiry go to PAUSE and set core_rst_n=1. Entering HOLD clears cycle_cnt and done.
- PAUSE: core_ce=0. Request priority, highest first: restart_req -> HOLD; run_req -> RUN; step_req -> STEP.
- RUN: core_ce=1 every cycle and cycle_cnt increments per core_ce cycle.
  - halt_req -> PAUSE, with core_ce=0 from the next cycle.
  - restart_req beats halt_req.
- STEP: core_ce=1 for exactly one cycle, then back to PAUSE. Requests arriving during STEP are ignored.
- Budget: when cycle_cnt reaches MAX_CYCLES-1 with core_ce=1, the next state is DONE regardless of halt_req.
  - DONE: done=1, core_ce=0, cycle_cnt holds MAX_CYCLES.
  - Only restart_req leaves DONE (-> HOLD).
  - MAX_CYCLES=0 disables the budget; cycle_cnt saturates at all-ones.
- restart_req in LOAD is ignored. run_req/step_req/halt_req outside their listed states are ignored.
- rst mid-load discards the partial program and restarts at address 0.

Optional Feature:
TD4_RUN_CTRL_CHECKSUM_EN
- With: LOAD accepts a 17th byte as a checksum. If the 8-bit modulo-256 sum of bytes 0..15 equals it, go to HOLD. Otherwise go to ERR (state=6): core_rst_n=0, ld_ready=1, pointer reset to 0, and a fresh 17-byte load leaves ERR. prog_we is never asserted for the checksum byte.
- Without: 16 bytes, no ERR state.

Decomposition:
- Package td4_pkg: state enum (LOAD..ERR), PROG_DEPTH=16, PROG_AW=4, WORD_W=8.
- One natural sub-module: td4_hold_timer (loadable down-counter with expiry pulse), used for the HOLD interval.

Test Plan:
- Load 16 bytes 0x00..0x0F with ld_valid held high -> prog_we high for 16 consecutive cycles, prog_addr 0..15; ld_ready low after byte 16; core_rst_n low 4 more cycles, then state=PAUSE.
- Load with ld_valid toggling every other cycle -> bytes written in order with no duplicates; prog_addr wraps to 0 on entering HOLD.
- PAUSE, run_req, MAX_CYCLES=250 -> core_ce high exactly 250 cycles, done=1, cycle_cnt=250, state=DONE; run_req in DONE is ignored.
- PAUSE, three step_req pulses 5 cycles apart -> three single-cycle core_ce pulses, cycle_cnt=3; halt_req during RUN at cycle_cnt=10 -> core_ce low next cycle, cycle_cnt holds 10.
- Same-cycle restart_req+halt_req in RUN -> HOLD, core_rst_n low 4 cycles, cycle_cnt=0, program untouched (no prog_we); rst asserted after byte 7 of a load -> next load starts at address 0.
- Checksum build: 16 bytes 0x01 plus checksum 0x10 -> HOLD; checksum 0x11 -> state=6, core_rst_n=0, ld_ready=1.

Source files
------------

// File: rtl/td4_pkg.sv
// Shared types and sizes for the TD4 run controller slice.
package td4_pkg;
  localparam int PROG_DEPTH = 16;
  localparam int PROG_AW    = 4;
  localparam int WORD_W     = 8;

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_HOLD  = 3'd1,
    S_PAUSE = 3'd2,
    S_RUN   = 3'd3,
    S_STEP  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } td4_state_e;

  typedef struct packed {
    logic               we;
    logic [PROG_AW-1:0] addr;
    logic [WORD_W-1:0]  wdata;
  } prog_wr_t;
endpackage

// File: rtl/td4_hold_timer.sv
// Loadable down-counter; expire pulses on the last enabled cycle of the interval.
module td4_hold_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                  cnt <= '0;
    else if (load)            cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - W'(1);
  end

  assign expire = en && (cnt == W'(1));
endmodule

// File: rtl/td4_run_ctrl.sv
// TD4 run controller: program load, core reset hold, run/step/halt, cycle budget.
// Build option TD4_RUN_CTRL_CHECKSUM_EN adds a checksum byte and the ERR state.
module td4_run_ctrl
  import td4_pkg::*;
#(
  parameter int RST_CYCLES = 4,
  parameter int MAX_CYCLES = 250,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld_valid,
  input  logic [WORD_W-1:0]  ld_data,
  output logic               ld_ready,
  input  logic               run_req,
  input  logic               step_req,
  input  logic               halt_req,
  input  logic               restart_req,
  output logic               prog_we,
  output logic [PROG_AW-1:0] prog_addr,
  output logic [WORD_W-1:0]  prog_wdata,
  output logic               core_rst_n,
  output logic               core_ce,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic               done
);
  localparam logic [PROG_AW-1:0] LAST_ADDR = PROG_AW'(PROG_DEPTH - 1);
  localparam logic [CNT_W-1:0]   LAST_CNT  = CNT_W'(MAX_CYCLES - 1);
  localparam bit                 BUDGET_EN = (MAX_CYCLES != 0);

  td4_state_e         st, st_nxt;
  logic [PROG_AW-1:0] ptr;
  prog_wr_t           wr;
  logic               hs, data_byte, last_byte, at_budget, hold_load, hold_exp;

  assign ld_ready = (st == S_LOAD) || (st == S_ERR);
  assign hs       = ld_valid && ld_ready;

`ifdef TD4_RUN_CTRL_CHECKSUM_EN
  logic              csum_ph;
  logic [WORD_W-1:0] csum;
  assign data_byte = hs && !csum_ph;
  assign last_byte = hs && csum_ph;
`else
  assign data_byte = hs;
  assign last_byte = hs && (ptr == LAST_ADDR);
`endif

  assign core_ce    = (st == S_RUN) || (st == S_STEP);
  assign core_rst_n = !((st == S_LOAD) || (st == S_HOLD) || (st == S_ERR));
  assign done       = (st == S_DONE);
  assign state      = st;
  assign at_budget  = BUDGET_EN && core_ce && (cycle_cnt == LAST_CNT);
  assign hold_load  = (st_nxt == S_HOLD) && (st != S_HOLD);

  assign prog_we    = wr.we;
  assign prog_addr  = wr.addr;
  assign prog_wdata = wr.wdata;

  td4_hold_timer #(.W(4)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (hold_load),
    .load_val (4'(RST_CYCLES)),
    .en       (st == S_HOLD),
    .expire   (hold_exp)
  );

  always_comb begin
    st_nxt = st;
    case (st)
      S_LOAD, S_ERR: if (last_byte) begin
`ifdef TD4_RUN_CTRL_CHECKSUM_EN
        st_nxt = (csum == ld_data) ? S_HOLD : S_ERR;
`else
        st_nxt = S_HOLD;
`endif
      end
      S_HOLD:  if (hold_exp) st_nxt = S_PAUSE;
      S_PAUSE: begin
        if (restart_req)   st_nxt = S_HOLD;
        else if (run_req)  st_nxt = S_RUN;
        else if (step_req) st_nxt = S_STEP;
      end
      // Restart wins over everything; the budget wins over halt.
      S_RUN: begin
        if (restart_req)    st_nxt = S_HOLD;
        else if (at_budget) st_nxt = S_DONE;
        else if (halt_req)  st_nxt = S_PAUSE;
      end
      S_STEP:  st_nxt = at_budget ? S_DONE : S_PAUSE;
      S_DONE:  if (restart_req) st_nxt = S_HOLD;
      default: st_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= S_LOAD;
      ptr       <= '0;
      wr        <= '0;
      cycle_cnt <= '0;
    end else begin
      st      <= st_nxt;
      wr.we   <= data_byte;
      // Address trails the pointer by a cycle so it lines up with the strobe.
      wr.addr <= ptr;
      if (data_byte) begin
        wr.wdata <= ld_data;
        ptr      <= ptr + PROG_AW'(1);
      end
      if (st_nxt == S_HOLD)                cycle_cnt <= '0;
      else if (core_ce && cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

`ifdef TD4_RUN_CTRL_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || last_byte) begin
      csum_ph <= 1'b0;
      csum    <= '0;
    end else if (data_byte) begin
      csum <= csum + ld_data;
      if (ptr == LAST_ADDR) csum_ph <= 1'b1;
    end
  end
`endif
endmodule
